// File: rtl/pll_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package pll_pkg;

  typedef enum logic [2:0] {PRST, WLOCK, STAB, REL, RUN, FAIL} state_t;

  localparam logic [1:0] DOM_25  = 2'd0;
  localparam logic [1:0] DOM_100 = 2'd1;
  localparam logic [1:0] DOM_50  = 2'd2;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level signal.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset control and ordered per-domain reset release, clocked from the reference clock.
module pll_reset_seq
  import pll_pkg::*;
#(
  parameter int unsigned PLL_RST_CYC  = 16,
  parameter int unsigned LOCK_TIMEOUT = 50000,
  parameter int unsigned STABLE_CYC   = 1024,
  parameter int unsigned RELEASE_GAP  = 8,
  parameter int unsigned MAX_RETRY    = 4
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       sw_reinit,
  output logic       pll_rst,
  output logic [2:0] dom_rst,
  output logic       ready,
  output logic       lock_fail,
  output logic [7:0] loss_cnt
);

  localparam int unsigned TMAX = max2(max2(PLL_RST_CYC, LOCK_TIMEOUT),
                                      max2(STABLE_CYC, 2 * RELEASE_GAP));
  localparam int unsigned TW = $clog2(TMAX + 1);
  localparam int unsigned RW = $clog2(MAX_RETRY + 1);

  localparam logic [TW-1:0] T_PRST = TW'(PLL_RST_CYC - 1);
  localparam logic [TW-1:0] T_LOCK = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] T_STAB = TW'(STABLE_CYC - 1);
  localparam logic [TW-1:0] T_GAP1 = TW'(RELEASE_GAP - 1);
  localparam logic [TW-1:0] T_GAP2 = TW'(2 * RELEASE_GAP - 1);
  localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRY);

  state_t        state, nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [RW-1:0] retry, retry_nxt;
  logic [2:0]    dom_nxt;
  logic          loss_inc;
  logic          lk_s;

  sync_2ff u_lock_sync (
    .clk   (clkin),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lk_s)
  );

  always_comb begin
    nxt       = state;
    timer_nxt = (timer == '1) ? timer : timer + 1'b1;
    retry_nxt = retry;
    loss_inc  = 1'b0;
    if (sw_reinit) begin
      nxt       = PRST;
      timer_nxt = '0;
      retry_nxt = '0;
      loss_inc  = (state == RUN) && !lk_s;
    end else begin
      unique case (state)
        PRST: if (timer == T_PRST) begin
          nxt       = WLOCK;
          timer_nxt = '0;
        end
        WLOCK: if (lk_s) begin
          nxt       = STAB;
          timer_nxt = '0;
        end else if (timer == T_LOCK) begin
          timer_nxt = '0;
          retry_nxt = retry + 1'b1;
          nxt       = (retry_nxt == R_MAX) ? FAIL : PRST;
        end
        STAB: if (!lk_s) begin
          nxt       = WLOCK;
          timer_nxt = '0;
        end else if (timer == T_STAB) begin
          nxt       = REL;
          timer_nxt = '0;
        end
        REL: if (!lk_s) begin
          nxt       = PRST;
          timer_nxt = '0;
        end else if (timer == T_GAP2) begin
          nxt       = RUN;
          timer_nxt = '0;
          retry_nxt = '0;
        end
        RUN: if (!lk_s) begin
          nxt       = PRST;
          timer_nxt = '0;
          loss_inc  = 1'b1;
        end
        FAIL: timer_nxt = '0;
        default: begin
          nxt       = PRST;
          timer_nxt = '0;
        end
      endcase
    end
  end

  // Release bits only clear while heading into REL/RUN; any other destination reasserts all three.
  always_comb begin
    dom_nxt = dom_rst;
    unique case (nxt)
      REL: begin
        dom_nxt[DOM_100] = 1'b0;
        if (state == REL && timer == T_GAP1) dom_nxt[DOM_50] = 1'b0;
      end
      RUN:     dom_nxt = '0;
      default: dom_nxt = '1;
    endcase
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PRST;
      timer     <= '0;
      retry     <= '0;
      pll_rst   <= 1'b1;
      dom_rst   <= '1;
      ready     <= 1'b0;
      lock_fail <= 1'b0;
      loss_cnt  <= '0;
    end else begin
      state     <= nxt;
      timer     <= timer_nxt;
      retry     <= retry_nxt;
      pll_rst   <= (nxt == PRST) || (nxt == FAIL);
      dom_rst   <= dom_nxt;
      ready     <= (nxt == RUN);
      lock_fail <= (nxt == FAIL);
      if (loss_inc && loss_cnt != '1) loss_cnt <= loss_cnt + 1'b1;
    end
  end

endmodule
